// File: rtl/tcni_pkg.sv
// Shared TCNI definitions: receiver state codes and header field layout.
package tcni_pkg;

   // Receiver state; the numeric value is what software reads on status.
   typedef enum logic [2:0] {
      TCNI_RECV_IDLE  = 3'd0,
      TCNI_RECV_WAIT  = 3'd1,
      TCNI_RECV_RECV  = 3'd2,
      TCNI_RECV_DONE  = 3'd3,
      TCNI_RECV_DROP  = 3'd4,
      TCNI_RECV_ERROR = 3'd5
   } tcni_recv_state;

   // Payload length field inside the header flit.
   localparam int HDR_LEN_OFFSET = 0;
   localparam int HDR_LEN_WIDTH  = 16;

endpackage

// File: rtl/tcni_cycle_counter.sv
// Free-running cycle counter shared by the TCNI sender and receiver.
module tcni_cycle_counter #(
   parameter int width = 32
) (
   input  logic             clock_in,
   input  logic             reset_in,
   output logic [width-1:0] count
);

   localparam logic [width-1:0] LP_ONE = 1;

   logic [width-1:0] r_count;

   // Count every cycle from zero; wraps naturally at 2^width.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) r_count <= '0;
      else           r_count <= r_count + LP_ONE;
   end

   assign count = r_count;

endmodule

// File: rtl/tcni_receiver.sv
// TCNI receive endpoint: accepts one packet at a time from the flit stream,
// writes its payload to a software-chosen word buffer and reports status.
module tcni_receiver
   import tcni_pkg::*;
#(
   parameter int MEMORY_BUS_WIDTH  = 32,
   parameter int MAX_PAYLOAD_FLITS = 64
) (
   input  logic                          clock_in,
   input  logic                          reset_in,
   input  logic [MEMORY_BUS_WIDTH-1:0]   rx_data_in,
   input  logic                          rx_valid_in,
   output logic                          rx_ready_out,
   output logic [MEMORY_BUS_WIDTH-1:0]   addr_out,
   output logic [MEMORY_BUS_WIDTH-1:0]   data_out,
   output logic [3:0]                    wb_out,
   input  logic [MEMORY_BUS_WIDTH-1:2]   recv_location_in,
   input  logic                          recv_enable_in,
   input  logic                          recv_ack_in,
   output logic [2:0]                    status,
   output logic [MEMORY_BUS_WIDTH-1:0]   arrival_time_out,
   output logic [15:0]                   recv_size_out
);

   localparam int AW = MEMORY_BUS_WIDTH - 2;
   localparam logic [HDR_LEN_WIDTH-1:0] LP_MAX_LEN = HDR_LEN_WIDTH'(MAX_PAYLOAD_FLITS);
   localparam logic [HDR_LEN_WIDTH-1:0] LP_LEN_ONE = 1;
   localparam logic [AW-1:0]            LP_IDX_ONE = 1;

   tcni_recv_state              r_state;
   logic [AW-1:0]               r_idx;
   logic [HDR_LEN_WIDTH-1:0]    r_remaining;
   logic [MEMORY_BUS_WIDTH-1:0] r_addr;
   logic [MEMORY_BUS_WIDTH-1:0] r_data;
   logic [3:0]                  r_wb;
   logic [MEMORY_BUS_WIDTH-1:0] r_arrival;
   logic [15:0]                 r_size;

   logic [MEMORY_BUS_WIDTH-1:0] w_count;
   logic                        w_xfer;
   logic [HDR_LEN_WIDTH-1:0]    w_hdr_len;
   logic [AW-1:0]               w_word_addr;

   tcni_cycle_counter #(
      .width(MEMORY_BUS_WIDTH)
   ) u_cycle_counter (
      .clock_in(clock_in),
      .reset_in(reset_in),
      .count   (w_count)
   );

   assign rx_ready_out = (r_state == TCNI_RECV_WAIT) ||
                         (r_state == TCNI_RECV_RECV) ||
                         (r_state == TCNI_RECV_DROP);
   assign w_xfer       = rx_valid_in && rx_ready_out;
   assign w_hdr_len    = rx_data_in[HDR_LEN_OFFSET +: HDR_LEN_WIDTH];
   // Word address wraps modulo 2^AW; the carry out is intentionally dropped.
   assign w_word_addr  = recv_location_in + r_idx;

   // Packet FSM with header capture and payload index/remaining bookkeeping.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         r_state     <= TCNI_RECV_IDLE;
         r_idx       <= '0;
         r_remaining <= '0;
         r_arrival   <= '0;
         r_size      <= '0;
      end else begin
         case (r_state)
            TCNI_RECV_IDLE: begin
               if (recv_enable_in) r_state <= TCNI_RECV_WAIT;
            end
            TCNI_RECV_WAIT: begin
               if (w_xfer) begin
                  r_arrival   <= w_count;
                  r_size      <= w_hdr_len;
                  r_idx       <= '0;
                  r_remaining <= w_hdr_len;
                  if (w_hdr_len == '0)            r_state <= TCNI_RECV_DONE;
                  else if (w_hdr_len > LP_MAX_LEN) r_state <= TCNI_RECV_DROP;
                  else                             r_state <= TCNI_RECV_RECV;
               end else if (!recv_enable_in) begin
                  r_state <= TCNI_RECV_IDLE;
               end
            end
            TCNI_RECV_RECV: begin
               if (w_xfer) begin
                  r_idx       <= r_idx + LP_IDX_ONE;
                  r_remaining <= r_remaining - LP_LEN_ONE;
                  if (r_remaining == LP_LEN_ONE) r_state <= TCNI_RECV_DONE;
               end
            end
            TCNI_RECV_DROP: begin
               if (w_xfer) begin
                  r_remaining <= r_remaining - LP_LEN_ONE;
                  if (r_remaining == LP_LEN_ONE) r_state <= TCNI_RECV_ERROR;
               end
            end
            TCNI_RECV_DONE, TCNI_RECV_ERROR: begin
               if (recv_ack_in)
                  r_state <= recv_enable_in ? TCNI_RECV_WAIT : TCNI_RECV_IDLE;
            end
            default: r_state <= TCNI_RECV_IDLE;
         endcase
      end
   end

   // Registered memory write port: one write cycle per accepted payload flit.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         r_addr <= '0;
         r_data <= '0;
         r_wb   <= 4'b0000;
      end else if (w_xfer && (r_state == TCNI_RECV_RECV)) begin
         r_addr <= {w_word_addr, 2'b00};
         r_data <= rx_data_in;
         r_wb   <= 4'b1111;
      end else begin
         r_wb   <= 4'b0000;
      end
   end

   assign addr_out         = r_addr;
   assign data_out         = r_data;
   assign wb_out           = r_wb;
   assign status           = r_state;
   assign arrival_time_out = r_arrival;
   assign recv_size_out    = r_size;

endmodule

// File: tb/tb_tcni_receiver.sv
// Randomized self-checking bench for tcni_receiver with a packet-level model.
module tb_tcni_receiver;

   logic        clk;
   logic        reset_in;
   logic [31:0] rx_data_in;
   logic        rx_valid_in;
   logic        rx_ready_out;
   logic [31:0] addr_out;
   logic [31:0] data_out;
   logic [3:0]  wb_out;
   logic [31:2] recv_location_in;
   logic        recv_enable_in;
   logic        recv_ack_in;
   logic [2:0]  status;
   logic [31:0] arrival_time_out;
   logic [15:0] recv_size_out;
   logic [3:0]  w_cnt4;

   tcni_receiver #(
      .MEMORY_BUS_WIDTH (32),
      .MAX_PAYLOAD_FLITS(64)
   ) dut (
      .clock_in        (clk),
      .reset_in        (reset_in),
      .rx_data_in      (rx_data_in),
      .rx_valid_in     (rx_valid_in),
      .rx_ready_out    (rx_ready_out),
      .addr_out        (addr_out),
      .data_out        (data_out),
      .wb_out          (wb_out),
      .recv_location_in(recv_location_in),
      .recv_enable_in  (recv_enable_in),
      .recv_ack_in     (recv_ack_in),
      .status          (status),
      .arrival_time_out(arrival_time_out),
      .recv_size_out   (recv_size_out)
   );

   // Narrow instance of the shared counter so wrap-around is reachable.
   tcni_cycle_counter #(.width(4)) u_cnt4 (
      .clock_in(clk),
      .reset_in(reset_in),
      .count   (w_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] wq[$];

   // Reference model: packet-level view of the receiver.
   int          m_state;
   logic [31:0] m_cnt;
   logic [31:0] m_arr;
   logic [15:0] m_size;
   int          m_len;
   int          m_got;
   logic [3:0]  m_wb;
   logic [31:0] m_addr;
   logic [31:0] m_data;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_arr = 0; m_size = 0;
      m_len = 0; m_got = 0; m_wb = 0; m_addr = 0; m_data = 0;
   endtask

   task automatic model_update();
      logic        rdy;
      logic        xfer;
      logic [29:0] wa;
      if (!reset_in) begin
         model_reset();
         return;
      end
      rdy  = (m_state == 1) || (m_state == 2) || (m_state == 4);
      xfer = rx_valid_in && rdy;
      m_wb = 4'b0000;
      case (m_state)
         0: if (recv_enable_in) m_state = 1;
         1: begin
            if (xfer) begin
               m_arr  = m_cnt;
               m_size = rx_data_in[15:0];
               m_len  = int'(rx_data_in[15:0]);
               m_got  = 0;
               if (m_len == 0)       m_state = 3;
               else if (m_len <= 64) m_state = 2;
               else                  m_state = 4;
            end else if (!recv_enable_in) m_state = 0;
         end
         2: if (xfer) begin
            wa     = recv_location_in + 30'(m_got);
            m_addr = {wa, 2'b00};
            m_data = rx_data_in;
            m_wb   = 4'b1111;
            m_got++;
            if (m_got == m_len) m_state = 3;
         end
         4: if (xfer) begin
            m_got++;
            if (m_got == m_len) m_state = 5;
         end
         3, 5: if (recv_ack_in) m_state = recv_enable_in ? 1 : 0;
         default: m_state = 0;
      endcase
      m_cnt = m_cnt + 32'd1;
   endtask

   task automatic compare_all();
      logic exp_rdy;
      exp_rdy = (m_state == 1) || (m_state == 2) || (m_state == 4);
      chk_val("status", 32'(status), 32'(m_state));
      chk_val("rx_ready", 32'(rx_ready_out), 32'(exp_rdy));
      chk_val("wb", 32'(wb_out), 32'(m_wb));
      if (m_wb != 4'b0000) begin
         chk_val("addr", addr_out, m_addr);
         chk_val("data", data_out, m_data);
      end
      chk_val("arrival", arrival_time_out, m_arr);
      chk_val("size", 32'(recv_size_out), 32'(m_size));
      chk_val("cnt4", 32'(w_cnt4), 32'(m_cnt[3:0]));
      if (wb_out == 4'b1111) wq.push_back(addr_out);
   endtask

   // One clock: model steps at the edge, outputs compared at the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic send_flit(input logic [31:0] d, input int gap);
      for (int g = 0; g < gap; g++) begin
         rx_valid_in = 1'b0;
         rx_data_in  = $urandom;
         cyc();
      end
      rx_valid_in = 1'b1;
      rx_data_in  = d;
      cyc();
      rx_valid_in = 1'b0;
   endtask

   task automatic ack_pulse(input logic en);
      recv_enable_in = en;
      recv_ack_in    = 1'b1;
      cyc();
      recv_ack_in    = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nw;
      int len;
      int r;
      reset_in         = 1'b0;
      rx_data_in       = '0;
      rx_valid_in      = 1'b0;
      recv_location_in = '0;
      recv_enable_in   = 1'b0;
      recv_ack_in      = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      reset_in = 1'b1;

      // Basic three-flit packet at word 0x100, back-to-back.
      recv_location_in = 30'h100;
      recv_enable_in   = 1'b1;
      cyc();
      wq.delete();
      send_flit(32'h0000_0003, 0);
      send_flit(32'h0000_000A, 0);
      send_flit(32'h0000_000B, 0);
      send_flit(32'h0000_000C, 0);
      chk_val("pkt3_status", 32'(status), 32'd3);
      chk_val("pkt3_size", 32'(recv_size_out), 32'd3);
      chk_val("pkt3_nwrites", 32'(wq.size()), 32'd3);
      if (wq.size() == 3) begin
         chk_val("pkt3_addr0", wq[0], 32'h400);
         chk_val("pkt3_addr1", wq[1], 32'h404);
         chk_val("pkt3_addr2", wq[2], 32'h408);
      end
      ack_pulse(1'b1);
      chk_val("pkt3_ack_status", 32'(status), 32'd1);

      // Zero-length packet, then ack with reception disarmed.
      nw = wq.size();
      send_flit(32'hBEEF_0000, 0);
      chk_val("len0_status", 32'(status), 32'd3);
      ack_pulse(1'b0);
      chk_val("len0_ack_status", 32'(status), 32'd0);
      chk_val("len0_nwrites", 32'(wq.size()), 32'(nw));

      // Oversize packet is drained without writes and flagged.
      recv_enable_in = 1'b1;
      cyc();
      send_flit(32'h0000_0041, 0);
      chk_val("drop_status", 32'(status), 32'd4);
      for (int i = 0; i < 65; i++) send_flit($urandom, 0);
      chk_val("drop_end_status", 32'(status), 32'd5);
      chk_val("drop_nwrites", 32'(wq.size()), 32'(nw));
      ack_pulse(1'b1);
      chk_val("drop_ack_status", 32'(status), 32'd1);

      // Valid toggling every other cycle: four writes only.
      nw = wq.size();
      send_flit(32'h0000_0004, 0);
      for (int i = 0; i < 4; i++) send_flit($urandom, 1);
      cyc();
      chk_val("toggle_nwrites", 32'(wq.size()), 32'(nw + 4));
      ack_pulse(1'b1);

      // Reset mid-payload.
      send_flit(32'h0000_0005, 0);
      send_flit($urandom, 0);
      send_flit($urandom, 0);
      reset_in = 1'b0;
      #1;
      chk_val("rst_status", 32'(status), 32'd0);
      chk_val("rst_ready", 32'(rx_ready_out), 32'd0);
      chk_val("rst_wb", 32'(wb_out), 32'd0);
      chk_val("rst_addr", addr_out, 32'd0);
      chk_val("rst_data", data_out, 32'd0);
      chk_val("rst_arrival", arrival_time_out, 32'd0);
      chk_val("rst_size", 32'(recv_size_out), 32'd0);
      model_reset();
      recv_enable_in = 1'b0;
      cyc();
      reset_in = 1'b1;
      cyc();
      chk_val("post_rst_status", 32'(status), 32'd0);
      chk_val("post_rst_ready", 32'(rx_ready_out), 32'd0);

      // Disarm in WAIT returns to IDLE.
      recv_enable_in = 1'b1;
      cyc();
      chk_val("arm_status", 32'(status), 32'd1);
      recv_enable_in = 1'b0;
      cyc();
      chk_val("disarm_status", 32'(status), 32'd0);

      // Randomized packets with gaps, ignored ack/enable activity, wrapping buffers.
      for (int p = 0; p < 40; p++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = 0;
         else if (r == 1) len = 64;
         else if (r == 2) len = 65 + $urandom_range(0, 10);
         else             len = $urandom_range(1, 20);
         recv_location_in = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFF0 + 30'($urandom_range(0, 15))
                                                        : 30'($urandom);
         recv_enable_in = 1'b1;
         recv_ack_in    = 1'b1;
         cyc();
         recv_ack_in    = 1'b0;
         send_flit({16'($urandom), 16'(len)}, $urandom_range(0, 2));
         for (int i = 0; i < len; i++) begin
            recv_ack_in    = ($urandom_range(0, 7) == 0);
            recv_enable_in = ($urandom_range(0, 3) != 0);
            send_flit($urandom, $urandom_range(0, 2));
            recv_ack_in    = 1'b0;
         end
         cyc();
         ack_pulse($urandom_range(0, 1) == 1);
      end

      // Counter wrap of the narrow instance across a long idle stretch.
      recv_enable_in = 1'b0;
      for (int i = 0; i < 20; i++) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
